// File: rtl/div_pkg.sv
// div_pkg: shared FSM state encoding and default operand width for seq_divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/div_step_unit.sv
// div_step_unit: one combinational restoring shift-subtract step.
module div_step_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-2:0] rem,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);
  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   diff;
  // The partial remainder never reaches the top bit before a shift, so it is carried as WIDTH-1 bits.
  assign shifted  = {rem, in_bit};
  assign diff     = {1'b0, shifted} - {1'b0, divisor};
  assign q_bit    = ~diff[WIDTH];
  assign rem_next = diff[WIDTH] ? shifted : diff[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: WIDTH-cycle restoring unsigned divider (IDLE/CALC/DONE FSM).
// Define DIV_ZERO_DETECT_EN to short-cut a zero divisor straight to DONE with dbz=1.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           state, state_next;
  logic [WIDTH-1:0] q_reg, div_reg, rem_next, q_shift;
  logic [WIDTH-2:0] rem_reg;
  logic [CW-1:0]    cnt;
  logic             q_bit, last, zero, dbz_r;
`ifdef DIV_ZERO_DETECT_EN
  assign zero = divisor == '0;
`else
  assign zero = 1'b0;
`endif
  div_step_unit #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .in_bit   (q_reg[WIDTH-1]),
    .divisor  (div_reg),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );
  assign q_shift = {q_reg[WIDTH-2:0], q_bit};
  assign last    = cnt == CW'(1);
  assign busy    = state == CALC;
  assign done    = state == DONE;
  assign dbz     = dbz_r;
  always_comb begin
    state_next = state == IDLE ? (start ? (zero ? DONE : CALC) : IDLE) :
                 state == CALC ? (last ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg     <= '0;
      div_reg   <= '0;
      rem_reg   <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz_r     <= 1'b0;
    end else if (state == IDLE && start) begin
      q_reg   <= dividend;
      div_reg <= divisor;
      rem_reg <= '0;
      cnt     <= CW'(WIDTH);
      if (zero) begin
        quotient  <= '1;
        remainder <= dividend;
        dbz_r     <= 1'b1;
      end
    end else if (state == CALC) begin
      q_reg   <= q_shift;
      rem_reg <= rem_next[WIDTH-2:0];
      cnt     <= cnt - CW'(1);
      if (last) begin
        quotient  <= q_shift;
        remainder <= rem_next;
        dbz_r     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized self-checking bench for seq_divider against an arithmetic model.
module tb_seq_divider;
  localparam int W = 8;
  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0, quotient, remainder;
  logic         busy, done, dbz;
  int           n_tests = 0, n_fail = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
    int n, lat, extra;
    logic [W-1:0] eq, er;
    bit edbz;
    eq = (b == 0) ? '1 : W'(a / b);
    er = (b == 0) ? a : W'(a % b);
    lat = W + 1;
    edbz = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
    if (b == 0) begin lat = 1; edbz = 1'b1; end
`endif
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (disturb) begin
        dividend = ~a; divisor = b + 3; start = (n == 3);
      end
      if (n == 1 && lat > 1) check("busy_calc", busy, 1);
    end while (!done && n < 40);
    start = 1'b0;
    check("latency", n, lat);
    check("busy_at_done", busy, 0);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("dbz", dbz, edbz);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    if (disturb) begin
      extra = 0;
      for (int i = 0; i < W + 4; i++) begin
        @(negedge clk);
        if (done) extra++;
      end
      check("extra_done", extra, 0);
      check("quotient_hold", quotient, eq);
    end
  endtask

  initial begin
    int cyc, first, second, seen;
    logic [W-1:0] a, b;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", dbz, 0);
    @(negedge clk); rst = 1'b0;
    run_op(8'd100, 8'd7, 0);
    run_op(8'd255, 8'd1, 0);
    run_op(8'd5, 8'd9, 0);
    run_op(8'd42, 8'd0, 0);
    run_op(8'd100, 8'd7, 1);
    run_op(8'd255, 8'd200, 0);
    // abort in the 4th CALC cycle
    run_op(8'd100, 8'd7, 0);
    @(negedge clk);
    dividend = 8'd50; divisor = 8'd3; start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", seen, 0);
    run_op(8'd200, 8'd10, 0);
    // start held high continuously
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    cyc = 0; first = -1; second = -1;
    while (cyc < 60 && second < 0) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (first < 0) first = cyc;
        else second = cyc;
      end
    end
    start = 1'b0;
    check("b2b_first", first, W + 1);
    check("b2b_spacing", second - first, W + 2);
    check("b2b_quotient", quotient, 14);
    repeat (W + 3) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom_range(0, 255));
      b = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 255));
      run_op(a, b, ($urandom_range(0, 3) == 0));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
